demux_scan_ctrl: RTL and testbench



---
 rtl/demux_scan_ctrl.sv | 104 ++++++++++
 tb/tb_demux_scan_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_scan_ctrl.sv
// Scan controller for a 1x4 demultiplexer: serialises a latched 4-bit word onto
// channels a..d, holding each channel for DWELL cycles with break-before-make selects.
module demux_scan_ctrl #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode_cont,
  input  logic [3:0]       data_in,
  output logic             y,
  output logic             S_0,
  output logic             S_1,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;

  localparam int              DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

  if (DWELL < 1) begin : g_dwell_check
    $error("demux_scan_ctrl: DWELL must be at least 1");
  end

  logic [1:0]      state;
  logic [3:0]      shadow;
  logic [1:0]      ch;
  logic [DW_W-1:0] dwell_cnt;

  // The channel index doubles as the registered select; it is parked at 0 in IDLE.
  assign S_0 = ch[0];
  assign S_1 = ch[1];

  // NOTE: every register here uses non-blocking assignment so all updates see
  // the pre-edge values; blocking writes would make later statements read new state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      y         <= 1'b0;
      ch        <= 2'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
      shadow    <= 4'd0;
      dwell_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            shadow <= data_in;
            ch     <= 2'd0;
            busy   <= 1'b1;
            state  <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          y         <= shadow[ch];
          dwell_cnt <= '0;
          state     <= ST_DRIVE;
        end

        ST_DRIVE: begin
          if (dwell_cnt != DWELL_LAST) begin
            dwell_cnt <= dwell_cnt + DW_W'(1);
          end else begin
            // y drops together with any select change, so selects never move under a high y.
            y <= 1'b0;
            if (ch != 2'd3) begin
              ch    <= ch + 2'd1;
              state <= ST_SETUP;
            end else begin
              frame_cnt <= frame_cnt + CNT_W'(1);
              done      <= 1'b1;
              ch        <= 2'd0;
              if (mode_cont) begin
                shadow <= data_in;
                state  <= ST_SETUP;
              end else begin
                busy  <= 1'b0;
                state <= ST_IDLE;
              end
            end
          end
        end

        default: begin
          state <= ST_IDLE;
          y     <= 1'b0;
          ch    <= 2'd0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Self-checking bench: two instances (DWELL=2/CNT_W=8 and DWELL=1/CNT_W=2) against a
// frame-position reference model, plus a vector table and directed multi-cycle sequences.
module tb_demux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] din = 4'd0;

  logic       y_a, s0_a, s1_a, busy_a, done_a;
  logic [7:0] cnt_a;
  logic       y_b, s0_b, s1_b, busy_b, done_b;
  logic [1:0] cnt_b;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  demux_scan_ctrl #(.DWELL(2), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .mode_cont(mode), .data_in(din),
    .y(y_a), .S_0(s0_a), .S_1(s1_a), .busy(busy_a), .done(done_a), .frame_cnt(cnt_a)
  );

  demux_scan_ctrl #(.DWELL(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .mode_cont(mode), .data_in(din),
    .y(y_b), .S_0(s0_b), .S_1(s1_b), .busy(busy_b), .done(done_b), .frame_cnt(cnt_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: a frame is just a cycle position t in 1..4*(1+d).
  typedef struct {
    bit         busy;
    int         t;
    logic [3:0] word;
    int         cnt;
    bit         done;
  } mstate_t;

  localparam mstate_t M_RESET = '{busy: 1'b0, t: 0, word: 4'd0, cnt: 0, done: 1'b0};

  mstate_t ma = M_RESET;
  mstate_t mb = M_RESET;

  function automatic mstate_t step(mstate_t m, bit st, bit md, logic [3:0] w, int d);
    mstate_t n;
    n      = m;
    n.done = 1'b0;
    if (!m.busy) begin
      if (st) begin
        n.busy = 1'b1;
        n.t    = 1;
        n.word = w;
      end
    end else if (m.t == 4 * (1 + d)) begin
      n.cnt  = m.cnt + 1;
      n.done = 1'b1;
      if (md) begin
        n.t    = 1;
        n.word = w;
      end else begin
        n.busy = 1'b0;
      end
    end else begin
      n.t = m.t + 1;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= M_RESET;
      mb <= M_RESET;
    end else begin
      ma <= step(ma, start, mode, din, 2);
      mb <= step(mb, start, mode, din, 1);
    end
  end

  task automatic cmp_model(input string tag, input logic yy, input logic [1:0] ss,
                           input logic bb, input logic dd, input int cc,
                           input mstate_t m, input int d, input int cw);
    int ch_i, ph;
    ch_i = m.busy ? (m.t - 1) / (d + 1) : 0;
    ph   = m.busy ? (m.t - 1) % (d + 1) : 0;
    check({tag, "_busy"}, bb, m.busy);
    check({tag, "_done"}, dd, m.done);
    check({tag, "_y"}, yy, (m.busy && ph != 0) ? m.word[ch_i] : 1'b0);
    check({tag, "_sel"}, ss, ch_i);
    check({tag, "_cnt"}, cc, m.cnt % (1 << cw));
  endtask

  logic [1:0] prev_s_a = 2'd0;
  logic [1:0] prev_s_b = 2'd0;

  // Continuous comparison against the model plus the break-before-make invariant.
  always @(negedge clk) begin
    cmp_model("model_a", y_a, {s1_a, s0_a}, busy_a, done_a, cnt_a, ma, 2, 8);
    cmp_model("model_b", y_b, {s1_b, s0_b}, busy_b, done_b, cnt_b, mb, 1, 2);
    if (y_a) check("bbm_a", {s1_a, s0_a}, prev_s_a);
    if (y_b) check("bbm_b", {s1_b, s0_b}, prev_s_b);
    prev_s_a = {s1_a, s0_a};
    prev_s_b = {s1_b, s0_b};
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    din   = 4'd0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_y_a"}, y_a, 1'b0);
    check({tag, "_sel_a"}, {s1_a, s0_a}, 2'd0);
    check({tag, "_busy_a"}, busy_a, 1'b0);
    check({tag, "_done_a"}, done_a, 1'b0);
    check({tag, "_cnt_a"}, cnt_a, 8'd0);
    check({tag, "_y_b"}, y_b, 1'b0);
    check({tag, "_busy_b"}, busy_b, 1'b0);
    check({tag, "_cnt_b"}, cnt_b, 2'd0);
  endtask

  // One 12-cycle frame of instance a; the channel pattern is rebuilt from y/select.
  task automatic run_frame(input logic [3:0] exp_word, input logic [3:0] din_next,
                           input logic mode_next, input bit want_done);
    logic [3:0] pat;
    pat = 4'd0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start = 1'b0;
        din   = din_next;
        if (want_done) check("cont_done_spacing", done_a, 1'b1);
        check("cont_busy", busy_a, 1'b1);
      end
      if (i == 6) mode = mode_next;
      if (y_a) pat[{s1_a, s0_a}] = 1'b1;
    end
    check("cont_pattern", pat, exp_word);
  endtask

  typedef struct {
    bit         start;
    logic [3:0] din;
    bit         y;
    logic [1:0] s;
    bit         busy;
    bit         done;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int         cyc;
    bit         seen;
    logic [1:0] exp_cnt_b[5];

    tbl[0]  = '{1'b0, 4'b1010, 1'b0, 2'd0, 1'b1, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 4'b1010, 1'b0, 2'd0, 1'b1, 1'b0, 8'd0};
    tbl[2]  = '{1'b0, 4'b1010, 1'b0, 2'd0, 1'b1, 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 4'b0101, 1'b0, 2'd1, 1'b1, 1'b0, 8'd0};
    tbl[4]  = '{1'b1, 4'b0101, 1'b1, 2'd1, 1'b1, 1'b0, 8'd0};
    tbl[5]  = '{1'b1, 4'b0101, 1'b1, 2'd1, 1'b1, 1'b0, 8'd0};
    tbl[6]  = '{1'b0, 4'b0101, 1'b0, 2'd2, 1'b1, 1'b0, 8'd0};
    tbl[7]  = '{1'b0, 4'b0101, 1'b0, 2'd2, 1'b1, 1'b0, 8'd0};
    tbl[8]  = '{1'b0, 4'b0101, 1'b0, 2'd2, 1'b1, 1'b0, 8'd0};
    tbl[9]  = '{1'b0, 4'b0101, 1'b0, 2'd3, 1'b1, 1'b0, 8'd0};
    tbl[10] = '{1'b0, 4'b0101, 1'b1, 2'd3, 1'b1, 1'b0, 8'd0};
    tbl[11] = '{1'b0, 4'b0101, 1'b1, 2'd3, 1'b1, 1'b0, 8'd0};
    tbl[12] = '{1'b0, 4'b0101, 1'b0, 2'd0, 1'b0, 1'b1, 8'd1};
    tbl[13] = '{1'b0, 4'b0101, 1'b0, 2'd0, 1'b0, 1'b0, 8'd1};
    exp_cnt_b = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    #1 rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;

    // Random activity, then an asynchronous reset between clock edges.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 199) == 0) #2 rst = 1'b1;
      start = ($urandom_range(0, 3) == 0);
      mode  = 1'($urandom_range(0, 1));
      din   = 4'($urandom);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    mode  = 1'b0;

    // Single 1010 frame with a mid-frame start/data change.
    do_reset();
    din   = 4'b1010;
    start = 1'b1;
    foreach (tbl[i]) begin
      @(negedge clk);
      check($sformatf("vec%0d_y", i), y_a, tbl[i].y);
      check($sformatf("vec%0d_sel", i), {s1_a, s0_a}, tbl[i].s);
      check($sformatf("vec%0d_busy", i), busy_a, tbl[i].busy);
      check($sformatf("vec%0d_done", i), done_a, tbl[i].done);
      check($sformatf("vec%0d_cnt", i), cnt_a, tbl[i].cnt);
      start = tbl[i].start;
      din   = tbl[i].din;
    end

    // Three back-to-back continuous frames; mode dropped during the third.
    do_reset();
    mode  = 1'b1;
    din   = 4'b1111;
    start = 1'b1;
    run_frame(4'b1111, 4'b0001, 1'b1, 1'b0);
    run_frame(4'b0001, 4'b1000, 1'b1, 1'b1);
    run_frame(4'b1000, 4'b1000, 1'b0, 1'b1);
    @(negedge clk);
    check("cont_end_done", done_a, 1'b1);
    check("cont_end_busy", busy_a, 1'b0);
    check("cont_end_cnt", cnt_a, 8'd3);
    @(negedge clk);
    check("cont_idle_busy", busy_a, 1'b0);
    check("cont_idle_done", done_a, 1'b0);

    // Reset while channel c is driven high.
    do_reset();
    din   = 4'b0100;
    start = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_rst_y", y_a, 1'b1);
    check("pre_rst_sel", {s1_a, s0_a}, 2'd2);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_y", y_a, 1'b0);
    check("mid_rst_sel", {s1_a, s0_a}, 2'd0);
    check("mid_rst_busy", busy_a, 1'b0);
    check("mid_rst_cnt", cnt_a, 8'd0);
    @(negedge clk);
    rst   = 1'b0;
    din   = 4'b0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_setup_sel", {s1_a, s0_a}, 2'd0);
    check("restart_setup_y", y_a, 1'b0);
    check("restart_busy", busy_a, 1'b1);
    @(negedge clk);
    check("restart_drive_y", y_a, 1'b1);
    check("restart_drive_sel", {s1_a, s0_a}, 2'd0);
    repeat (12) @(negedge clk);

    // Counter wrap on the DWELL=1, CNT_W=2 instance over five continuous frames.
    do_reset();
    mode  = 1'b1;
    din   = 4'b0110;
    start = 1'b1;
    for (int f = 0; f < 5; f++) begin
      seen = 1'b0;
      cyc  = 0;
      while (!seen && cyc < 20) begin
        @(negedge clk);
        start = 1'b0;
        cyc++;
        seen = done_b;
      end
      check($sformatf("wrap_done_seen%0d", f), seen, 1'b1);
      check($sformatf("wrap_spacing%0d", f), cyc, (f == 0) ? 9 : 8);
      check($sformatf("wrap_cnt%0d", f), cnt_b, exp_cnt_b[f]);
    end
    mode = 1'b0;
    cyc  = 0;
    while ((busy_a || busy_b) && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("final_idle_a", busy_a, 1'b0);
    check("final_idle_b", busy_b, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
